// File: rtl/clint_timer_if.sv
// Core data-memory port as seen by the timer block: address/store strobes in, load data out.
interface clint_timer_if #(
  parameter int unsigned MSK_WIDTH = 4
);
  logic [31:0]          io_dmem_addr;
  logic                 io_dmem_type;
  logic [31:0]          io_dmem_wdata;
  logic [MSK_WIDTH-1:0] io_dmem_wmask;
  logic [31:0]          io_dmem_rdata;

  modport master (
    output io_dmem_addr, io_dmem_type, io_dmem_wdata, io_dmem_wmask,
    input  io_dmem_rdata
  );

  modport slave (
    input  io_dmem_addr, io_dmem_type, io_dmem_wdata, io_dmem_wmask,
    output io_dmem_rdata
  );
endinterface

// File: rtl/clint_timer.sv
// CLINT-style machine timer: 64-bit mtime/mtimecmp plus msip, memory-mapped on the dmem port,
// driving registered timer/software interrupt flags.
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned MSK_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  clint_timer_if.slave   dmem,
  output logic           io_interrupt,
  output logic           io_mtip,
  output logic           io_msip
);

  localparam int unsigned OFF_W  = 14;
  localparam int unsigned PCNT_W = 16;
  localparam logic [OFF_W-1:0]  OFF_MSIP    = 14'h0000;
  localparam logic [OFF_W-1:0]  OFF_CMP_LO  = 14'h1000;
  localparam logic [OFF_W-1:0]  OFF_CMP_HI  = 14'h1001;
  localparam logic [OFF_W-1:0]  OFF_TIME_LO = 14'h2FFE;
  localparam logic [OFF_W-1:0]  OFF_TIME_HI = 14'h2FFF;
  localparam logic [PCNT_W-1:0] PCNT_MAX    = PCNT_W'(PRESCALE - 1);

  logic [63:0]        mtime, mtime_n;
  logic [63:0]        mtimecmp, mtimecmp_n;
  logic               msip, msip_n;
  logic [PCNT_W-1:0]  pcnt, pcnt_n;
  logic               mtip_n, irq_n;

  logic               sel, wr, tick;
  logic [OFF_W-1:0]   off;
  logic [MSK_WIDTH-1:0] wmask;
  logic [3:0]         be;
  logic [1:0]         unused_addr_lsb;

  // Byte-enable merge of store data into a 32-bit register half
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] en);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign sel             = (dmem.io_dmem_addr[31:16] == BASE_ADDR[31:16]);
  assign off             = dmem.io_dmem_addr[15:2];
  assign unused_addr_lsb = dmem.io_dmem_addr[1:0];
  assign wr              = sel & dmem.io_dmem_type;
  assign wmask           = dmem.io_dmem_wmask;
  assign be              = 4'(wmask);
  assign tick            = (pcnt == PCNT_MAX);

  // Combinational load mux over current register values
  always_comb begin
    dmem.io_dmem_rdata = 32'h0;
    if (sel) begin
      case (off)
        OFF_MSIP:    dmem.io_dmem_rdata = {31'h0, msip};
        OFF_CMP_LO:  dmem.io_dmem_rdata = mtimecmp[31:0];
        OFF_CMP_HI:  dmem.io_dmem_rdata = mtimecmp[63:32];
        OFF_TIME_LO: dmem.io_dmem_rdata = mtime[31:0];
        OFF_TIME_HI: dmem.io_dmem_rdata = mtime[63:32];
        default:     dmem.io_dmem_rdata = 32'h0;
      endcase
    end
  end

  // Next-state: a store to either mtime half suppresses that cycle's increment
  always_comb begin
    pcnt_n     = tick ? '0 : pcnt + PCNT_W'(1);
    mtime_n    = mtime;
    mtimecmp_n = mtimecmp;
    msip_n     = msip;

    if (wr && (off == OFF_TIME_LO || off == OFF_TIME_HI)) begin
      if (off == OFF_TIME_LO) mtime_n[31:0]  = merge(mtime[31:0],  dmem.io_dmem_wdata, be);
      if (off == OFF_TIME_HI) mtime_n[63:32] = merge(mtime[63:32], dmem.io_dmem_wdata, be);
    end else if (tick) begin
      mtime_n = mtime + 64'd1;
    end

    if (wr && off == OFF_CMP_LO) mtimecmp_n[31:0]  = merge(mtimecmp[31:0],  dmem.io_dmem_wdata, be);
    if (wr && off == OFF_CMP_HI) mtimecmp_n[63:32] = merge(mtimecmp[63:32], dmem.io_dmem_wdata, be);
    if (wr && off == OFF_MSIP && be[0]) msip_n = dmem.io_dmem_wdata[0];

    mtip_n = (mtime >= mtimecmp);
    irq_n  = mtip_n | msip;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime        <= 64'h0;
      mtimecmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip         <= 1'b0;
      pcnt         <= '0;
      io_mtip      <= 1'b0;
      io_msip      <= 1'b0;
      io_interrupt <= 1'b0;
    end else begin
      mtime        <= mtime_n;
      mtimecmp     <= mtimecmp_n;
      msip         <= msip_n;
      pcnt         <= pcnt_n;
      io_mtip      <= mtip_n;
      io_msip      <= msip;
      io_interrupt <= irq_n;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_clint_timer;

  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clint_timer_if #(.MSK_WIDTH(4)) bus1 ();
  clint_timer_if #(.MSK_WIDTH(4)) bus4 ();

  logic irq1, mtip1, msip1, irq4, mtip4, msip4;

  clint_timer #(.BASE_ADDR(32'h0200_0000), .PRESCALE(1), .MSK_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .dmem(bus1),
    .io_interrupt(irq1), .io_mtip(mtip1), .io_msip(msip1));

  clint_timer #(.BASE_ADDR(32'h0200_0000), .PRESCALE(4), .MSK_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .dmem(bus4),
    .io_interrupt(irq4), .io_mtip(mtip4), .io_msip(msip4));

  int errors = 0;
  int checks = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p4, input logic [31:0] a, input logic t,
                       input logic [31:0] d, input logic [3:0] m);
    if (p4) begin
      bus4.io_dmem_addr = a; bus4.io_dmem_type = t; bus4.io_dmem_wdata = d; bus4.io_dmem_wmask = m;
    end else begin
      bus1.io_dmem_addr = a; bus1.io_dmem_type = t; bus1.io_dmem_wdata = d; bus1.io_dmem_wmask = m;
    end
  endtask

  // Store for one cycle; returns the load data visible during the store cycle
  task automatic st(input bit p4, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m, output logic [31:0] rd_old);
    drive(p4, a, 1'b1, d, m);
    #1;
    rd_old = p4 ? bus4.io_dmem_rdata : bus1.io_dmem_rdata;
    cyc();
    drive(p4, 32'h0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic ld(input bit p4, input logic [31:0] a, output logic [31:0] d);
    drive(p4, a, 1'b0, 32'h0, 4'h0);
    #1;
    d = p4 ? bus4.io_dmem_rdata : bus1.io_dmem_rdata;
  endtask

  function automatic logic [31:0] wa(input logic [15:0] off);
    return {16'h0200, off};
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0;
    repeat (3) cyc();
    ld(0, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mtime_lo got %h exp %h", v, 32'h0); end
    ld(0, wa(OFF_CMP_LO), v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo got %h exp %h", v, 32'hFFFF_FFFF); end
    ld(0, wa(OFF_CMP_HI), v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi got %h exp %h", v, 32'hFFFF_FFFF); end
    ld(0, wa(OFF_MSIP), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_msip got %h exp %h", v, 32'h0); end
    ld(1, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mtime4 got %h exp %h", v, 32'h0); end
    checks++; if ({irq1, mtip1, msip1, irq4} !== 4'b0) begin
      errors++; $display("FAIL reset_irq got %b exp %b", {irq1, mtip1, msip1, irq4}, 4'b0); end
    rst = 1'b1;
    cyc();
    ld(1, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL presc_first1 got %h exp %h", v, 32'h0); end
    cyc();
    ld(1, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL presc_first2 got %h exp %h", v, 32'h0); end
    repeat (3) cyc();
    ld(1, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL presc_first_tick got %h exp %h", v, 32'h1); end
  endtask

  task automatic test_count_carry();
    logic [31:0] v, o;
    st(0, wa(OFF_TIME_LO), 32'hFFFF_FFFE, 4'hF, o);
    st(0, wa(OFF_TIME_HI), 32'h0, 4'hF, o);
    ld(0, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL carry_hold got %h exp %h", v, 32'hFFFF_FFFE); end
    cyc();
    ld(0, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL carry_pre got %h exp %h", v, 32'hFFFF_FFFF); end
    cyc();
    ld(0, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL carry_lo got %h exp %h", v, 32'h0); end
    ld(0, wa(OFF_TIME_HI), v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL carry_hi got %h exp %h", v, 32'h1); end
  endtask

  task automatic test_timer_irq();
    logic [31:0] v, o;
    int seen, rise;
    st(0, wa(OFF_TIME_LO), 32'h0, 4'hF, o);
    st(0, wa(OFF_TIME_HI), 32'h0, 4'hF, o);
    st(0, wa(OFF_CMP_LO), 32'h20, 4'hF, o);
    st(0, wa(OFF_CMP_HI), 32'h0, 4'hF, o);
    ld(0, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL mtip_setup got %h exp %h", v, 32'h2); end
    seen = -1;
    rise = -1;
    for (int k = 0; k < 64; k++) begin
      ld(0, wa(OFF_TIME_LO), v);
      if (v == 32'h20 && seen < 0) seen = k;
      if (mtip1 === 1'b1 && rise < 0) rise = k;
      if (rise >= 0) break;
      cyc();
    end
    checks++; if (seen !== 30) begin errors++; $display("FAIL mtip_reach got %0d exp %0d", seen, 30); end
    checks++; if (rise !== 31) begin errors++; $display("FAIL mtip_rise got %0d exp %0d", rise, 31); end
    st(0, wa(OFF_CMP_HI), 32'hFFFF_FFFF, 4'hF, o);
    checks++; if ({mtip1, irq1} !== 2'b11) begin
      errors++; $display("FAIL mtip_hold got %b exp %b", {mtip1, irq1}, 2'b11); end
    cyc();
    checks++; if ({mtip1, irq1} !== 2'b00) begin
      errors++; $display("FAIL mtip_fall got %b exp %b", {mtip1, irq1}, 2'b00); end
  endtask

  task automatic test_soft_irq();
    logic [31:0] v, o;
    st(0, wa(OFF_MSIP), 32'h1, 4'b0010, o);
    ld(0, wa(OFF_MSIP), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL msip_mask_rd got %h exp %h", v, 32'h0); end
    cyc();
    checks++; if (msip1 !== 1'b0) begin errors++; $display("FAIL msip_mask_out got %b exp %b", msip1, 1'b0); end
    st(0, wa(OFF_MSIP), 32'h1, 4'b0001, o);
    checks++; if (o !== 32'h0) begin errors++; $display("FAIL msip_old_rd got %h exp %h", o, 32'h0); end
    ld(0, wa(OFF_MSIP), v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL msip_new_rd got %h exp %h", v, 32'h1); end
    checks++; if (msip1 !== 1'b0) begin errors++; $display("FAIL msip_n1 got %b exp %b", msip1, 1'b0); end
    cyc();
    checks++; if ({msip1, irq1} !== 2'b11) begin
      errors++; $display("FAIL msip_n2 got %b exp %b", {msip1, irq1}, 2'b11); end
  endtask

  task automatic test_decode();
    logic [31:0] v, v0, o;
    ld(0, wa(OFF_TIME_LO), v0);
    cyc();
    st(0, 32'h0300_BFF8, 32'h55, 4'hF, o);
    checks++; if (o !== 32'h0) begin errors++; $display("FAIL dec_other_rd got %h exp %h", o, 32'h0); end
    ld(0, wa(OFF_TIME_LO), v);
    checks++; if (v !== v0 + 32'd2) begin errors++; $display("FAIL dec_mtime got %h exp %h", v, v0 + 32'd2); end
    st(0, 32'h0200_1000, 32'hDEAD, 4'hF, o);
    ld(0, 32'h0200_1000, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL dec_unmapped got %h exp %h", v, 32'h0); end
    st(0, wa(OFF_CMP_LO), 32'h1234, 4'h0, o);
    ld(0, wa(OFF_CMP_LO), v);
    checks++; if (v !== 32'h20) begin errors++; $display("FAIL dec_cmp_lo got %h exp %h", v, 32'h20); end
    ld(0, wa(OFF_CMP_HI), v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dec_cmp_hi got %h exp %h", v, 32'hFFFF_FFFF); end
    ld(0, wa(OFF_MSIP), v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL dec_msip got %h exp %h", v, 32'h1); end
  endtask

  task automatic test_collision();
    logic [31:0] prev, cur, v, o, expv;
    bit found;
    found = 1'b0;
    ld(1, wa(OFF_TIME_LO), prev);
    cur = prev;
    for (int k = 0; k < 12; k++) begin
      cyc();
      ld(1, wa(OFF_TIME_LO), cur);
      if (cur != prev) begin found = 1'b1; break; end
      prev = cur;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL coll_find got %b exp %b", found, 1'b1); end
    expv = {cur[31:8], 8'hAA};
    repeat (3) cyc();
    st(1, wa(OFF_TIME_LO), 32'h0000_00AA, 4'b0001, o);
    ld(1, wa(OFF_TIME_LO), v);
    checks++; if (v !== expv) begin errors++; $display("FAIL coll_write got %h exp %h", v, expv); end
    ld(1, wa(OFF_TIME_HI), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL coll_hi got %h exp %h", v, 32'h0); end
    repeat (3) cyc();
    ld(1, wa(OFF_TIME_LO), v);
    checks++; if (v !== expv) begin errors++; $display("FAIL coll_hold got %h exp %h", v, expv); end
    cyc();
    ld(1, wa(OFF_TIME_LO), v);
    checks++; if (v !== expv + 32'd1) begin errors++; $display("FAIL coll_next got %h exp %h", v, expv + 32'd1); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] v;
    checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL mrst_pre got %b exp %b", irq1, 1'b1); end
    drive(0, wa(OFF_TIME_LO), 1'b1, 32'h1234_5678, 4'hF);
    drive(1, wa(OFF_TIME_LO), 1'b0, 32'h0, 4'h0);
    #1;
    rst = 1'b0;
    #1;
    checks++; if ({irq1, msip1} !== 2'b00) begin
      errors++; $display("FAIL mrst_irq got %b exp %b", {irq1, msip1}, 2'b00); end
    checks++; if (bus1.io_dmem_rdata !== 32'h0) begin
      errors++; $display("FAIL mrst_mtime1 got %h exp %h", bus1.io_dmem_rdata, 32'h0); end
    checks++; if (bus4.io_dmem_rdata !== 32'h0) begin
      errors++; $display("FAIL mrst_mtime4 got %h exp %h", bus4.io_dmem_rdata, 32'h0); end
    drive(0, 32'h0, 1'b0, 32'h0, 4'h0);
    rst = 1'b1;
    cyc();
    ld(0, wa(OFF_CMP_LO), v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mrst_cmp got %h exp %h", v, 32'hFFFF_FFFF); end
    ld(0, wa(OFF_MSIP), v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mrst_msip got %h exp %h", v, 32'h0); end
    ld(0, wa(OFF_TIME_LO), v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL mrst_count got %h exp %h", v, 32'h1); end
  endtask

  initial begin
    drive(0, 32'h0, 1'b0, 32'h0, 4'h0);
    drive(1, 32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    test_reset();
    test_count_carry();
    test_timer_irq();
    test_soft_irq();
    test_decode();
    test_collision();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer and software-interrupt block on the core's data-memory port, in the style of a CLINT. It decodes core load/store traffic in its address window and keeps a free-running 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and a 1-bit `msip` register. It drives the core's `io_interrupt` input. It is the stage directly downstream of the core's dmem outputs and upstream of its interrupt input.

## Interface
- `BASE_ADDR`, default 32'h0200_0000: window base; only bits [31:16] are compared.
- `PRESCALE`, default 1: clk cycles per `mtime` tick, range 1..65535.
- `MSK_WIDTH`, default 4: byte-mask width, same as the core's dmem mask.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `io_dmem_addr`  in  32  byte address from the core.
- `io_dmem_type`  in  1  1 = store, 0 = load or idle.
- `io_dmem_wdata`  in  32  store data.
- `io_dmem_wmask`  in  MSK_WIDTH  byte enables; bit i enables wdata[8i+7:8i].
- `io_dmem_rdata`  out  32  load data; combinational, same cycle.
- `io_interrupt`  out  1  registered, equals `mtip_q | msip_q`.
- `io_mtip`  out  1  registered timer-pending flag.
- `io_msip`  out  1  registered software-pending flag.

## Operation
- Window select: `sel = (io_dmem_addr[31:16] == BASE_ADDR[31:16])`. The word offset is `io_dmem_addr[15:2]`; `addr[1:0]` is ignored.
- Register map (byte offsets):
  - 0x0000 `msip`: bit0 is read/write; bits [31:1] read 0.
  - 0x4000 `mtimecmp[31:0]`.
  - 0x4004 `mtimecmp[63:32]`.
  - 0xBFF8 `mtime[31:0]`.
  - 0xBFFC `mtime[63:32]`.
- Reads: `io_dmem_rdata` is a combinational mux of current register values.
  - Returns 0 when `sel=0` or the offset is unmapped.
  - Independent of `io_dmem_type`.
- Writes: occur when `sel & io_dmem_type`.
  - Each enabled byte of the addressed register is updated at the clock edge; disabled bytes hold.
  - Writes to unmapped offsets are ignored.
  - A write with mask 0 is a no-op.
- Prescaler: `pcnt` counts 0..PRESCALE-1 and wraps.
  - A tick occurs in the cycle where `pcnt == PRESCALE-1`.
  - With PRESCALE=1, every cycle is a tick.
- `mtime`: increments by 1 (full 64-bit, carry lo→hi) on a tick.
  - Wraps from all-ones to 0.
- Write/tick collision: a store to either `mtime` half in a tick cycle wins.
  - The written bytes take the store data.
  - The whole 64-bit counter does not increment that cycle; unwritten bytes hold.
  - `pcnt` still advances.
- Compare: `mtip_q <= (mtime >= mtimecmp)`, unsigned 64-bit, evaluated on current register values every cycle.
- `msip_q <= msip`.
- `mtimecmp` is not self-clearing. Software clears `mtip` by raising `mtimecmp`.

## Timing
- Reset (rst=0, asynchronous), effective immediately:
  - `mtime=0`, `pcnt=0`, `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF`, `msip=0`.
  - `mtip_q=0`, `msip_q=0`, `io_interrupt=0`, `io_mtip=0`, `io_msip=0`.
  - `io_dmem_rdata` reflects the reset register values.
- Reset deassertion is synchronised by the integrator. The first tick occurs PRESCALE cycles after the first active edge.
- Reset asserted mid-operation aborts any in-flight store; all state returns to the reset values.
- Store in cycle N: the register holds the new value from cycle N+1, and a load in cycle N+1 returns it.
  - A load in cycle N itself returns the old value.
- Interrupt latency: if a condition first holds in cycle N (register values), `io_mtip`/`io_msip`/`io_interrupt` assert in cycle N+1.
  - From a store in cycle N to the interrupt changing: cycle N+2.
- `mtime` lo/hi are not snapshotted. Software performs the hi-lo-hi read sequence to get a consistent 64-bit value.
- No stall or wait state; every access completes in one cycle.

## Test plan
- Reset: hold rst=0 for 3 cycles, release.
  - Required: reads of 0xBFF8, 0x4000, 0x4004 and 0x0000 return 0x0 (or small count), 0xFFFF_FFFF, 0xFFFF_FFFF and 0x0; `io_interrupt=0`.
- Count and carry (PRESCALE=1):
  - Store 0xFFFF_FFFE to 0xBFF8 and 0x0 to 0xBFFC.
  - Required: two cycles later, 0xBFF8 reads 0x0000_0000 and 0xBFFC reads 0x0000_0001.
- Timer interrupt:
  - Store 0x0 to 0x4004, then 0x20 to 0x4000, with `mtime`=0x10.
  - Required: `io_mtip` rises exactly when `mtime` reaches 0x20, plus one cycle.
  - Then store 0xFFFF_FFFF to 0x4004; `io_mtip` falls 2 cycles after the store.
- Software interrupt with masks:
  - Store 0x1 to 0x0000 with wmask 4'b0010. Required: no change, `io_msip=0`.
  - Repeat with wmask 4'b0001. Required: `io_msip=1` and `io_interrupt=1` two cycles after the store; a read returns 0x1.
- Collision and prescaler (PRESCALE=4):
  - Store 0x0000_00AA to 0xBFF8 with wmask 4'b0001 exactly in a tick cycle.
  - Required: `mtime` = {old[63:8], 0xAA} with no increment; the next increment comes 4 cycles later.
- Decode: store to 0x0300_BFF8 and to 0x0200_1000.
  - Required: no register changes; loads return 0x0.
- Mid-operation reset: pulse rst=0 for a fraction of a cycle while `io_interrupt=1`.
  - Required: immediately `io_interrupt=0` and `mtime=0`.
